// File: rtl/diff_commit_queue_if.sv
//------------------------------------------------------------------------------
// diff_commit_queue_if
// Writeback-record input and difftest-event output bundle for diff_commit_queue.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface diff_commit_queue_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_pc;
    logic [31:0] in_instr;
    logic        in_skip;
    logic        in_wen;
    logic [7:0]  in_wdest;
    logic [63:0] in_wdata;
    logic [7:0]  in_store_valid;
    logic [63:0] in_store_paddr;
    logic [63:0] in_store_data;
    logic [7:0]  in_store_len;
    logic        in_excp_valid;
    logic        in_is_mret;
    logic [31:0] in_cause;

    logic        out_instr_valid;
    logic [7:0]  out_index;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        out_skip;
    logic        out_wen;
    logic [7:0]  out_wdest;
    logic [63:0] out_wdata;
    logic [7:0]  out_store_valid;
    logic [7:0]  out_store_index;
    logic [63:0] out_store_paddr;
    logic [63:0] out_store_vaddr;
    logic [63:0] out_store_data;
    logic [7:0]  out_store_len;
    logic        out_excp_valid;
    logic        out_is_mret;
    logic [31:0] out_cause;
    logic [63:0] out_exception_pc;
    logic [31:0] out_exception_inst;
    logic [63:0] commit_count;
    logic        timeout;

    // master drives records in; slave is the queue itself
    modport master (
        output in_valid, in_pc, in_instr, in_skip, in_wen, in_wdest, in_wdata,
               in_store_valid, in_store_paddr, in_store_data, in_store_len,
               in_excp_valid, in_is_mret, in_cause,
        input  in_ready, out_instr_valid, out_index, out_pc, out_instr, out_skip,
               out_wen, out_wdest, out_wdata, out_store_valid, out_store_index,
               out_store_paddr, out_store_vaddr, out_store_data, out_store_len,
               out_excp_valid, out_is_mret, out_cause, out_exception_pc,
               out_exception_inst, commit_count, timeout
    );
    modport slave (
        input  in_valid, in_pc, in_instr, in_skip, in_wen, in_wdest, in_wdata,
               in_store_valid, in_store_paddr, in_store_data, in_store_len,
               in_excp_valid, in_is_mret, in_cause,
        output in_ready, out_instr_valid, out_index, out_pc, out_instr, out_skip,
               out_wen, out_wdest, out_wdata, out_store_valid, out_store_index,
               out_store_paddr, out_store_vaddr, out_store_data, out_store_len,
               out_excp_valid, out_is_mret, out_cause, out_exception_pc,
               out_exception_inst, commit_count, timeout
    );
endinterface

`default_nettype wire

// File: rtl/diff_commit_queue.sv
//------------------------------------------------------------------------------
// diff_commit_queue
// Retired-record FIFO replayed as difftest commit/store/exception events.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module diff_commit_queue #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 4096
) (
    input  wire logic          clock,
    input  wire logic          reset,
    diff_commit_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        skip;
        logic        wen;
        logic [7:0]  wdest;
        logic [63:0] wdata;
        logic [7:0]  store_valid;
        logic [63:0] store_paddr;
        logic [63:0] store_data;
        logic [7:0]  store_len;
        logic        excp_valid;
        logic        is_mret;
        logic [31:0] cause;
    } entry_t;

    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    entry_t        out_rec_q, out_rec_d;
    logic          instr_valid_q, instr_valid_d;
    logic          excp_valid_q, excp_valid_d;
    logic          is_mret_q, is_mret_d;
    logic [7:0]    store_valid_q, store_valid_d;
    logic [7:0]    out_index_q, out_index_d;
    logic [7:0]    idx_q, idx_d;
    logic [63:0]   commit_count_q, commit_count_d;
    logic [WW-1:0] wd_q, wd_d;
    logic          timeout_q, timeout_d;

    logic   full, empty, push, pop, trap;
    entry_t in_rec, head;

    always_comb begin
        in_rec = '{pc: bus.in_pc, instr: bus.in_instr, skip: bus.in_skip,
                   wen: bus.in_wen, wdest: bus.in_wdest, wdata: bus.in_wdata,
                   store_valid: bus.in_store_valid, store_paddr: bus.in_store_paddr,
                   store_data: bus.in_store_data, store_len: bus.in_store_len,
                   excp_valid: bus.in_excp_valid, is_mret: bus.in_is_mret,
                   cause: bus.in_cause};
    end

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // Occupancy is judged before this cycle's push, so a fresh entry waits one cycle
    assign push  = bus.in_valid && !full;
    assign pop   = !empty;
    assign head  = mem_q[rd_ptr_q[AW-1:0]];
    assign trap  = head.excp_valid && !head.is_mret;

    always_comb begin
        mem_d          = mem_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        out_rec_d      = out_rec_q;
        instr_valid_d  = 1'b0;
        excp_valid_d   = 1'b0;
        is_mret_d      = 1'b0;
        store_valid_d  = 8'd0;
        out_index_d    = out_index_q;
        idx_d          = idx_q;
        commit_count_d = commit_count_q;

        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = in_rec;
            wr_ptr_d                = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d      = rd_ptr_q + 1'b1;
            out_rec_d     = head;
            out_rec_d.wen = head.wen && (head.wdest != 8'd0);
            out_index_d   = idx_q;
            instr_valid_d = !trap;
            excp_valid_d  = head.excp_valid;
            is_mret_d     = head.excp_valid && head.is_mret;
            store_valid_d = trap ? 8'd0 : head.store_valid;
            if (!trap) begin
                idx_d          = idx_q + 8'd1;
                commit_count_d = commit_count_q + 64'd1;
            end
        end

        if (instr_valid_d || excp_valid_d)
            wd_d = '0;
        else if (wd_q == WW'(TIMEOUT))
            wd_d = wd_q;
        else
            wd_d = wd_q + 1'b1;
        timeout_d = timeout_q || (wd_d == WW'(TIMEOUT));
    end

    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            out_rec_q      <= '0;
            instr_valid_q  <= 1'b0;
            excp_valid_q   <= 1'b0;
            is_mret_q      <= 1'b0;
            store_valid_q  <= 8'd0;
            out_index_q    <= 8'd0;
            idx_q          <= 8'd0;
            commit_count_q <= 64'd0;
            wd_q           <= '0;
            timeout_q      <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            out_rec_q      <= out_rec_d;
            instr_valid_q  <= instr_valid_d;
            excp_valid_q   <= excp_valid_d;
            is_mret_q      <= is_mret_d;
            store_valid_q  <= store_valid_d;
            out_index_q    <= out_index_d;
            idx_q          <= idx_d;
            commit_count_q <= commit_count_d;
            wd_q           <= wd_d;
            timeout_q      <= timeout_d;
        end
    end

    assign bus.in_ready           = !full;
    assign bus.out_instr_valid    = instr_valid_q;
    assign bus.out_index          = out_index_q;
    assign bus.out_pc             = out_rec_q.pc;
    assign bus.out_instr          = out_rec_q.instr;
    assign bus.out_skip           = out_rec_q.skip;
    assign bus.out_wen            = out_rec_q.wen;
    assign bus.out_wdest          = out_rec_q.wdest;
    assign bus.out_wdata          = out_rec_q.wdata;
    assign bus.out_store_valid    = store_valid_q;
    assign bus.out_store_index    = out_index_q;
    assign bus.out_store_paddr    = out_rec_q.store_paddr;
    assign bus.out_store_vaddr    = out_rec_q.store_paddr;
    assign bus.out_store_data     = out_rec_q.store_data;
    assign bus.out_store_len      = out_rec_q.store_len;
    assign bus.out_excp_valid     = excp_valid_q;
    assign bus.out_is_mret        = is_mret_q;
    assign bus.out_cause          = out_rec_q.cause;
    assign bus.out_exception_pc   = out_rec_q.pc;
    assign bus.out_exception_inst = out_rec_q.instr;
    assign bus.commit_count       = commit_count_q;
    assign bus.timeout            = timeout_q;
endmodule

`default_nettype wire

// File: doc/diff_commit_queue.md
# diff_commit_queue

Commit-side collector directly upstream of the difftest bridge. Accepts one retired-instruction record per cycle from the writeback stage and buffers it in a small FIFO. Replays records one per cycle as aligned instruction-commit, store-event and exception-event fields with a running commit index. Also keeps a 64-bit commit counter and a sticky no-progress watchdog.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2
- TIMEOUT, 4096, cycles without a drained record before `timeout` sets; ≥2

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  record offered by writeback
- in_ready  out  1  queue can accept (= !full)
- in_pc  in  64  PC of the record
- in_instr  in  32  instruction word
- in_skip  in  1  difftest skip (MMIO access)
- in_wen  in  1  GPR write
- in_wdest  in  8  destination register
- in_wdata  in  64  write data
- in_store_valid  in  8  store byte-mask/type; 0 = no store
- in_store_paddr  in  64  store address (paddr = vaddr)
- in_store_data  in  64  store data
- in_store_len  in  8  store length in bytes
- in_excp_valid  in  1  record is a trap or mret
- in_is_mret  in  1  with in_excp_valid, record is mret
- in_cause  in  32  trap cause
- out_instr_valid  out  1  one-cycle commit pulse
- out_index  out  8  commit index
- out_pc, out_instr, out_skip, out_wen, out_wdest, out_wdata  out  64/32/1/1/8/64  commit fields
- out_store_valid, out_store_index, out_store_paddr, out_store_vaddr, out_store_data, out_store_len  out  8/8/64/64/64/8  store event
- out_excp_valid, out_is_mret, out_cause, out_exception_pc, out_exception_inst  out  1/1/32/64/32  exception event
- commit_count  out  64  total instructions committed
- timeout  out  1  sticky watchdog flag

## Operation
- **Enqueue:** a record is written when `in_valid && in_ready`. `in_ready = !full`. No enqueue bypass while full, even if a dequeue happens in the same cycle.
- **Dequeue:** when the FIFO is non-empty, one entry is popped every cycle. All out_* ports are registered from the popped entry.
  - When the FIFO is empty, `out_instr_valid`, `out_store_valid` and `out_excp_valid` are 0 for that cycle.
  - Data fields hold their last value.
- **Record classes:**
  - Normal (`!in_excp_valid`): `out_instr_valid = 1`, `out_excp_valid = 0`.
  - Trap (`in_excp_valid && !in_is_mret`): `out_instr_valid = 0`, `out_excp_valid = 1`, `out_exception_pc = pc`, `out_exception_inst = instr`. The store event is suppressed and no index is consumed.
  - Mret (`in_excp_valid && in_is_mret`): `out_instr_valid = 1`, `out_excp_valid = 1`, `out_is_mret = 1`.
- **Index:**
  - `out_index` = internal 8-bit counter value for each committed record.
  - The counter increments after each `out_instr_valid` and wraps 255 → 0.
  - `out_store_index = out_index` when `out_store_valid ≠ 0`.
- **Store address:** `out_store_vaddr = out_store_paddr`.
- **x0 writes:** `out_wen` is forced to 0 when `wdest == 0`; `out_wdata` is passed unchanged.
- **commit_count:** +1 per `out_instr_valid`; wraps at 2^64.
- **Watchdog:**
  - The counter resets to 0 on any cycle with `out_instr_valid` or `out_excp_valid`, otherwise increments, saturating at TIMEOUT.
  - `timeout` goes high on the cycle the counter reaches TIMEOUT and stays high until reset.
  - The watchdog has no effect on the datapath.

## Timing
- **Reset:** all outputs 0, FIFO empty, pointers 0, index 0, `commit_count` 0, watchdog 0, `timeout` 0. `in_ready` = 1 on the first cycle after reset.
- **Reset mid-operation:** buffered entries are discarded. No output pulse occurs in the cycle after reset.
- **Latency:** a record accepted at edge k into an empty FIFO appears on the outputs after edge k+1 (1-cycle visible lag). Records are drained back-to-back at one per cycle.
- **Full/empty:**
  - Full and empty are tracked with pointers one bit wider than log2(DEPTH).
  - Simultaneous push and pop on a non-full, non-empty FIFO leaves the occupancy unchanged.
  - A push into an empty FIFO is not popped in the same cycle.
- **Throughput:** sustained 1 record/cycle. `in_ready` never drops under continuous 1/cycle input, because pop keeps pace after the initial fill.

## Test plan
- **Reset then single record:** after reset, one record pc=0x80000000, wen=1, wdest=5, wdata=0x1234 → one cycle with out_instr_valid=1, out_index=0, out_wen=1, wdest=5; `commit_count` = 1.
- **x0 write and wrap:** 300 back-to-back normal records, record 3 with wdest=0, wen=1.
  - Record 3 → out_wen=0.
  - out_index sequence goes 0..255, 0..43.
  - `commit_count` = 300; `in_ready` stays 1 throughout.
- **Store event:** record with store_valid=0xFF, paddr=0x80001000, data=0xDEADBEEF, len=8 → the same cycle shows out_store_valid=0xFF, store_index = out_index, vaddr = paddr = 0x80001000.
- **Trap and mret:**
  - Trap (excp=1, cause=11, pc=0x80000100) → out_excp_valid=1, out_instr_valid=0, exception_pc=0x80000100, index not advanced.
  - Following mret → both valids 1, is_mret=1, index advances by 1.
- **Backpressure and reset:**
  - Drive in_valid while holding the FIFO full (DEPTH=4, force full via a hold-off fill) → in_ready=0 and no record lost or duplicated; the drain order matches the input order.
  - Assert reset with 3 entries queued → no output pulses afterwards, `commit_count` = 0.
- **Watchdog (TIMEOUT=16):** no input for 16 cycles → `timeout` = 1 on cycle 16 and remains 1 after new commits; only reset clears it.
